// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
package alu_sched_pkg;

  // ISSUE is folded into the IDLE grant edge; the encoding is kept for debug visibility.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [3:0] shift;
  } alu_req_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/alu_req_scheduler_arb.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  int j;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    j            = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any             = 1'b1;
        grant_onehot[j] = 1'b1;
        grant_idx       = W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one 8-bit ALU between NREQ requesters, one op in flight.
// Optional ALU_SCHED_STICKY_FLAGS_EN adds sticky_clr / sticky_flags accumulation of captured flags.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int ALU_LAT = 1,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  input  logic [NREQ*4-1:0] req_shift,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_s,
  output logic [3:0]        alu_shift,
  input  logic [7:0]        alu_y,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_y,
  output logic [2:0]        rsp_flags,
  output logic              busy
`ifdef ALU_SCHED_STICKY_FLAGS_EN
  ,
  input  logic              sticky_clr,
  output logic [2:0]        sticky_flags
`endif
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q;
  logic [2:0]      cnt_q;
  alu_req_t        alu_q, win;
  logic [IDW-1:0]  rsp_id_q;
  logic [7:0]      rsp_y_q;
  logic [2:0]      rsp_flags_q, cap_flags;
  logic            rsp_valid_q;

  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            capture;

  rr_arbiter #(.N(NREQ), .W(IDW)) u_arb (
    .req          (req_valid),
    .ptr          (ptr_q),
    .grant_onehot (gnt_oh),
    .grant_idx    (gnt_idx),
    .any          (gnt_any)
  );

  always_comb begin
    win.a     = req_a[8*int'(gnt_idx) +: 8];
    win.b     = req_b[8*int'(gnt_idx) +: 8];
    win.op    = req_op[3*int'(gnt_idx) +: 3];
    win.shift = req_shift[4*int'(gnt_idx) +: 4];
  end

  always_comb begin
    cap_flags             = '0;
    cap_flags[FLAG_ZERO]  = alu_zero;
    cap_flags[FLAG_CARRY] = alu_carry;
    cap_flags[FLAG_OVF]   = alu_ovf;
  end

  assign capture = (state_q == WAIT) && (cnt_q == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = WAIT;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) ? gnt_oh : '0;
    busy      = (state_q != IDLE);
  end

  // Datapath: operands latch only on the grant edge and then hold until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      alu_q       <= '0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt_any) begin
          alu_q    <= win;
          rsp_id_q <= gnt_idx;
          ptr_q    <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
          cnt_q    <= 3'(ALU_LAT-1);
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            rsp_y_q     <= alu_y;
            rsp_flags_q <= cap_flags;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: if (rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign alu_a     = alu_q.a;
  assign alu_b     = alu_q.b;
  assign alu_s     = alu_q.op;
  assign alu_shift = alu_q.shift;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;

`ifdef ALU_SCHED_STICKY_FLAGS_EN
  logic [2:0] sticky_q;

  // Clear applies first so a same-cycle capture still sets its own bits.
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= (sticky_clr ? 3'b000 : sticky_q) | (capture ? cap_flags : 3'b000);
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a small behavioural ALU; define ALU_SCHED_STICKY_FLAGS_EN to cover sticky flags.
module tb_alu_req_scheduler;

  localparam int NREQ = 2;
  localparam int LAT  = 1;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_XOR = 3'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a = '0;
  logic [NREQ*8-1:0] req_b = '0;
  logic [NREQ*3-1:0] req_op = '0;
  logic [NREQ*4-1:0] req_shift = '0;
  logic [7:0]        alu_a, alu_b, alu_y;
  logic [2:0]        alu_s;
  logic [3:0]        alu_shift;
  logic              alu_zero, alu_carry, alu_ovf;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [0:0]        rsp_id;
  logic [7:0]        rsp_y;
  logic [2:0]        rsp_flags;
  logic              busy;
`ifdef ALU_SCHED_STICKY_FLAGS_EN
  logic              sticky_clr = 1'b0;
  logic [2:0]        sticky_flags;
`endif

  int total = 0;
  int bad   = 0;
  int lat_n;

  always #5 clk = ~clk;

  alu_req_scheduler #(.NREQ(NREQ), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_shift(req_shift),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_shift(alu_shift),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .busy(busy)
`ifdef ALU_SCHED_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
`endif
  );

  // Behavioural ALU: ADD sets carry/overflow, XOR clears them
  logic [8:0] sum;
  always_comb begin
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_y     = alu_a;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_s)
      OP_ADD: begin
        alu_y     = sum[7:0];
        alu_carry = sum[8];
        alu_ovf   = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
      end
      OP_XOR:  alu_y = alu_a ^ alu_b;
      default: ;
    endcase
    alu_zero = (alu_y == 8'h00);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [3:0] sh);
    req_a[8*id +: 8]     = a;
    req_b[8*id +: 8]     = b;
    req_op[3*id +: 3]    = op;
    req_shift[4*id +: 4] = sh;
  endtask

  // Single requester raises valid from IDLE; checks same-cycle ready and the latched operands.
  task automatic issue_one(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input logic [3:0] sh);
    logic [NREQ-1:0] m;
    set_req(id, a, b, op, sh);
    m = '0;
    m[id] = 1'b1;
    req_valid = m;
    #1;
    chk("ready_grant", 16'(req_ready), 16'(m));
    step();
    req_valid = '0;
    chk("alu_a", 16'(alu_a), 16'(a));
    chk("alu_b", 16'(alu_b), 16'(b));
    chk("alu_s", 16'(alu_s), 16'(op));
    chk("alu_shift", 16'(alu_shift), 16'(sh));
    chk("busy_op", 16'(busy), 16'd1);
  endtask

  task automatic get_rsp(input int exp_id, input logic [7:0] exp_y, input logic [2:0] exp_f,
                         output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    lat = n;
    chk("rsp_timeout", 16'(rsp_valid), 16'd1);
    chk("rsp_id", 16'(rsp_id), 16'(exp_id));
    chk("rsp_y", 16'(rsp_y), 16'(exp_y));
    chk("rsp_flags", 16'(rsp_flags), 16'(exp_f));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_id;
    int n;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 16'(req_ready), 16'd0);
    chk("rst_valid", 16'(rsp_valid), 16'd0);
    chk("rst_id", 16'(rsp_id), 16'd0);
    chk("rst_y", 16'(rsp_y), 16'd0);
    chk("rst_flags", 16'(rsp_flags), 16'd0);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
`ifdef ALU_SCHED_STICKY_FLAGS_EN
    chk("rst_sticky", 16'(sticky_flags), 16'd0);
`endif

    // Single ADD, latency and operand hold after completion
    issue_one(0, 8'h0F, 8'h01, OP_ADD, 4'h3);
    get_rsp(0, 8'h10, 3'b000, lat_n);
    chk("latency", 16'(lat_n), 16'(LAT));
    chk("idle_after", 16'(busy), 16'd0);
    chk("rsp_drop", 16'(rsp_valid), 16'd0);
    chk("alu_hold", 16'(alu_a), 16'h0F);

    // Both valid continuously: pointer sits at 1, grants alternate
    set_req(0, 8'h01, 8'h02, OP_ADD, 4'h0);
    set_req(1, 8'h10, 8'h20, OP_ADD, 4'h0);
    req_valid = 2'b11;
    exp_id = 1;
    for (int k = 0; k < 20; k++) begin
      get_rsp(exp_id, (exp_id == 1) ? 8'h30 : 8'h03, 3'b000, n);
      exp_id = 1 - exp_id;
    end
    req_valid = '0;

    // Flag corners; lone requester 0 served while pointer is 1
    issue_one(0, 8'hFF, 8'h01, OP_ADD, 4'h0);
    get_rsp(0, 8'h00, 3'b011, n);
    issue_one(1, 8'h7F, 8'h01, OP_ADD, 4'h5);
    get_rsp(1, 8'h80, 3'b100, n);
`ifdef ALU_SCHED_STICKY_FLAGS_EN
    chk("sticky_acc", 16'(sticky_flags), 16'b111);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("sticky_clr0", 16'(sticky_flags), 16'd0);
    issue_one(0, 8'hFF, 8'h02, OP_ADD, 4'h0);
    get_rsp(0, 8'h01, 3'b010, n);
    issue_one(0, 8'h05, 8'h05, OP_XOR, 4'h0);
    get_rsp(0, 8'h00, 3'b001, n);
    chk("sticky_or", 16'(sticky_flags), 16'b011);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("sticky_clr1", 16'(sticky_flags), 16'd0);
    issue_one(1, 8'h01, 8'h01, OP_ADD, 4'h0);
    get_rsp(1, 8'h02, 3'b000, n);
`endif

    // Back-pressure in RESP: outputs hold, no grant until handshake
    rsp_ready = 1'b0;
    issue_one(0, 8'h05, 8'h03, OP_ADD, 4'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    set_req(0, 8'h11, 8'h22, OP_ADD, 4'h0);
    set_req(1, 8'h40, 8'h04, OP_ADD, 4'h0);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 16'(rsp_valid), 16'd1);
      chk("bp_y", 16'(rsp_y), 16'h08);
      chk("bp_id", 16'(rsp_id), 16'd0);
      chk("bp_ready", 16'(req_ready), 16'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_ready", 16'(req_ready), 16'd0);
    step();
    chk("post_hs_grant", 16'(req_ready), 16'b10);
    step();
    req_valid = '0;
    chk("post_hs_alu_a", 16'(alu_a), 16'h40);
    get_rsp(1, 8'h44, 3'b000, n);

    // Reset mid-op (pointer is 1 before reset, must return to 0)
    issue_one(0, 8'h12, 8'h34, OP_ADD, 4'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 16'(rsp_valid), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_alu_a", 16'(alu_a), 16'd0);
    chk("mid_rst_alu_s", 16'(alu_shift), 16'd0);
    chk("mid_rst_id", 16'(rsp_id), 16'd0);
    set_req(0, 8'h01, 8'h01, OP_ADD, 4'h0);
    set_req(1, 8'h02, 8'h02, OP_ADD, 4'h0);
    req_valid = 2'b11;
    #1;
    chk("mid_rst_ptr0", 16'(req_ready), 16'b01);
    chk("mid_rst_norsp", 16'(rsp_valid), 16'd0);
    step();
    req_valid = '0;
    get_rsp(0, 8'h02, 3'b000, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
